// File: rtl/usb_fifo_reader.sv
// Read-side controller for an FT245-style USB FIFO: strobes RD#, assembles
// little-endian stereo samples and hands complete frames out over valid/ready.
module usb_fifo_reader #(
    parameter int RD_LOW_CYCLES  = 4,
    parameter int RD_HIGH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_rxf_n,
    input  logic        fifo_pwren_n,
    output logic        fifo_rd_n,
    input  logic [2:0]  sample_size,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [31:0] sample_left,
    output logic [31:0] sample_right,
    output logic        byte_count_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, RECOVER = 2'd2} state_t;

    localparam logic [7:0] LOW_LAST  = 8'(RD_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LAST = 8'(RD_HIGH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        rd_n_nxt, capture;
    logic        rxf_meta, rxf_s, pwr_meta, pwr_s;
    logic        pending;
    logic [2:0]  byte_idx, size_lat, size_eff, nbytes;
    logic [3:0]  last_idx;
    logic        in_right, frame_done;
    logic [1:0]  byte_sel;
    logic [31:0] asm_left, asm_right, left_nxt, right_nxt;

    // Two-flop synchronizers; reset to the inactive (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
            pwr_meta <= 1'b1;
            pwr_s    <= 1'b1;
        end else begin
            rxf_meta <= fifo_rxf_n;
            rxf_s    <= rxf_meta;
            pwr_meta <= fifo_pwren_n;
            pwr_s    <= pwr_meta;
        end
    end

    // Strobe FSM state, cycle counter and registered RD#.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            fifo_rd_n <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            fifo_rd_n <= rd_n_nxt;
        end
    end

    // Next-state logic; a power loss mid-strobe still gets a full precharge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_n_nxt  = 1'b1;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxf_s && !pwr_s && !pending) begin
                    state_nxt = STROBE;
                    cnt_nxt   = 8'd0;
                    rd_n_nxt  = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            STROBE: begin
                if (pwr_s) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = 8'd0;
                end else if (cnt == LOW_LAST) begin
                    capture   = 1'b1;
                    state_nxt = RECOVER;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt  = cnt + 8'd1;
                    rd_n_nxt = 1'b0;
                end
            end
            RECOVER: begin
                if (cnt == HIGH_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Byte placement; the size code is taken live only for the first byte.
    always_comb begin
        size_eff = (byte_idx == 3'd0) ? sample_size : size_lat;
        case (size_eff)
            3'd0:    nbytes = 3'd1;
            3'd4:    nbytes = 3'd3;
            3'd5:    nbytes = 3'd4;
            default: nbytes = 3'd2;
        endcase
        in_right   = (byte_idx >= nbytes);
        byte_sel   = in_right ? 2'(byte_idx - nbytes) : byte_idx[1:0];
        last_idx   = ({1'b0, nbytes} << 1) - 4'd1;
        frame_done = capture && ({1'b0, byte_idx} == last_idx);
        left_nxt   = (byte_idx == 3'd0) ? 32'd0 : asm_left;
        right_nxt  = (byte_idx == 3'd0) ? 32'd0 : asm_right;
        if (in_right) begin
            right_nxt[{byte_sel, 3'b000} +: 8] = fifo_data;
        end else begin
            left_nxt[{byte_sel, 3'b000} +: 8] = fifo_data;
        end
        if (size_eff == 3'd1) begin
            left_nxt[31:12]  = 20'd0;
            right_nxt[31:12] = 20'd0;
        end else begin
            left_nxt[31:12]  = left_nxt[31:12];
            right_nxt[31:12] = right_nxt[31:12];
        end
    end

    // Assembly register, byte index and partial-frame error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx       <= 3'd0;
            size_lat       <= 3'd0;
            asm_left       <= 32'd0;
            asm_right      <= 32'd0;
            byte_count_err <= 1'b0;
        end else if (pwr_s && (byte_idx != 3'd0)) begin
            byte_idx       <= 3'd0;
            byte_count_err <= 1'b1;
        end else if (capture) begin
            if (byte_idx == 3'd0) begin
                size_lat <= sample_size;
            end
            asm_left  <= left_nxt;
            asm_right <= right_nxt;
            byte_idx  <= frame_done ? 3'd0 : byte_idx + 3'd1;
        end
    end

    // Output register handoff; a second frame waits in the assembly register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid  <= 1'b0;
            pending      <= 1'b0;
            sample_left  <= 32'd0;
            sample_right <= 32'd0;
        end else if (frame_done) begin
            if (!frame_valid || frame_ready) begin
                sample_left  <= left_nxt;
                sample_right <= right_nxt;
                frame_valid  <= 1'b1;
            end else begin
                pending <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            if (pending) begin
                sample_left  <= asm_left;
                sample_right <= asm_right;
                pending      <= 1'b0;
            end else begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_fifo_reader.sv
// Scoreboard bench for usb_fifo_reader: a FIFO model feeds bytes, a monitor
// checks every accepted frame against hand-computed expectations.
module tb_usb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  fifo_data = 8'd0;
    logic        fifo_rxf_n = 1'b1;
    logic        fifo_pwren_n = 1'b0;
    logic        fifo_rd_n;
    logic [2:0]  sample_size = 3'd3;
    logic        frame_ready = 1'b1;
    logic        frame_valid;
    logic [31:0] sample_left, sample_right;
    logic        byte_count_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0]  bq[$];
    logic [63:0] exp_q[$];

    usb_fifo_reader dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_rxf_n(fifo_rxf_n),
        .fifo_pwren_n(fifo_pwren_n), .fifo_rd_n(fifo_rd_n), .sample_size(sample_size),
        .frame_ready(frame_ready), .frame_valid(frame_valid), .sample_left(sample_left),
        .sample_right(sample_right), .byte_count_err(byte_count_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // FIFO model: present head byte, drop it when RD# returns high.
    initial forever begin
        #1;
        fifo_rxf_n = (bq.size() == 0);
        fifo_data  = (bq.size() != 0) ? bq[0] : 8'h00;
    end
    initial forever begin
        @(posedge fifo_rd_n);
        #1;
        if (bq.size() != 0) void'(bq.pop_front());
    end

    // Scoreboard monitor: compare each accepted frame.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            logic [63:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL frame_unexpected: got %h_%h, required none", sample_left, sample_right);
            end else begin
                e = exp_q.pop_front();
                if ({sample_left, sample_right} !== e) begin
                    bad++;
                    $display("FAIL frame: got %h_%h, required %h_%h", sample_left, sample_right, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_rd(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n <= max; n++) begin
            if (fifo_rd_n == lvl) begin
                ok = 1'b1;
                return;
            end
            if (n < max) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || bq.size() != 0 || frame_valid) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < max), 32'd1);
    endtask

    task automatic push_frame(input logic [31:0] l, input logic [31:0] r, input logic [7:0] b[]);
        exp_q.push_back({l, r});
        foreach (b[i]) bq.push_back(b[i]);
    endtask

    initial begin
        bit ok;
        int t0, w, lows;
        logic [7:0] b2[] = '{8'h34, 8'h12, 8'h78, 8'h56};

        #23;
        check("rst_rd_n", 32'(fifo_rd_n), 32'd1);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_left", sample_left, 32'd0);
        check("rst_right", sample_right, 32'd0);
        check("rst_err", 32'(byte_count_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 16b frame with RD# pulse timing
        sample_size = 3'd3;
        push_frame(32'h00001234, 32'h00005678, b2);
        wait_rd(1'b0, 100, ok);
        check("first_strobe_seen", 32'(ok), 32'd1);
        t0 = cyc;
        w = 0;
        while (fifo_rd_n == 1'b0 && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("rd_low_width", 32'(w), 32'd4);
        wait_rd(1'b0, 20, ok);
        check("rd_spacing", 32'(cyc - t0), 32'd8);
        wait_drain("drain16", 200);

        sample_size = 3'd1;
        push_frame(32'h00000BFF, 32'h00000321, '{8'hFF, 8'hAB, 8'h21, 8'hF3});
        wait_drain("drain12", 200);
        sample_size = 3'd4;
        push_frame(32'h00030201, 32'h00060504, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        wait_drain("drain24", 300);
        sample_size = 3'd0;
        push_frame(32'h0000009A, 32'h000000BC, '{8'h9A, 8'hBC});
        wait_drain("drain8", 200);
        sample_size = 3'd5;
        push_frame(32'h44332211, 32'h88776655,
                   '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
        wait_drain("drain32", 300);

        // backpressure: three frames, consumer stalled
        sample_size = 3'd3;
        frame_ready = 1'b0;
        push_frame(32'h0000A1A0, 32'h0000A3A2, '{8'hA0, 8'hA1, 8'hA2, 8'hA3});
        push_frame(32'h0000B1B0, 32'h0000B3B2, '{8'hB0, 8'hB1, 8'hB2, 8'hB3});
        push_frame(32'h0000C1C0, 32'h0000C3C2, '{8'hC0, 8'hC1, 8'hC2, 8'hC3});
        w = 0;
        while (!frame_valid && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("bp_first_valid", 32'(frame_valid), 32'd1);
        repeat (60) @(negedge clk);
        check("bp_queue_stalled", 32'(bq.size()), 32'd4);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (fifo_rd_n == 1'b0) lows++;
            @(negedge clk);
        end
        check("bp_rd_held_high", 32'(lows), 32'd0);
        check("bp_left_stable", sample_left, 32'h0000A1A0);
        @(posedge clk);
        #1 frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        check("bp_second_left", sample_left, 32'h0000B1B0);
        check("bp_second_valid", 32'(frame_valid), 32'd1);
        @(negedge clk);
        wait_rd(1'b0, 4, ok);
        check("bp_reads_resume", 32'(ok), 32'd1);
        frame_ready = 1'b1;
        wait_drain("drain_bp", 300);

        // PWREN# loss after 3 of 4 bytes
        check("err_before", 32'(byte_count_err), 32'd0);
        bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
        w = 0;
        while (bq.size() != 0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        fifo_pwren_n = 1'b1;
        repeat (6) @(negedge clk);
        check("pwr_err_set", 32'(byte_count_err), 32'd1);
        check("pwr_no_valid", 32'(frame_valid), 32'd0);
        fifo_pwren_n = 1'b0;
        repeat (4) @(negedge clk);
        push_frame(32'h00004433, 32'h00006655, '{8'h33, 8'h44, 8'h55, 8'h66});
        wait_drain("drain_pwr", 200);

        // size change mid-frame: current frame stays 16b
        sample_size = 3'd3;
        push_frame(32'h00000201, 32'h00000403, '{8'h01, 8'h02, 8'h03, 8'h04});
        push_frame(32'h40302010, 32'h80706050,
                   '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80});
        w = 0;
        while (bq.size() > 11 && w < 100) begin
            w++;
            @(negedge clk);
        end
        sample_size = 3'd5;
        wait_drain("drain_size", 400);

        // abort mid-strobe
        bq.push_back(8'hEE);
        wait_rd(1'b0, 100, ok);
        fifo_pwren_n = 1'b1;
        wait_rd(1'b1, 3, ok);
        check("abort_rd_high", 32'(ok), 32'd1);
        repeat (8) @(negedge clk);
        check("abort_no_valid", 32'(frame_valid), 32'd0);
        bq.delete();
        fifo_pwren_n = 1'b0;
        repeat (4) @(negedge clk);

        // async reset mid-strobe with a frame on the output
        frame_ready = 1'b0;
        foreach (b2[i]) bq.push_back(b2[i]);
        w = 0;
        while (!frame_valid && w < 100) begin
            w++;
            @(negedge clk);
        end
        bq.push_back(8'h5A);
        wait_rd(1'b0, 100, ok);
        #2 rst = 1'b1;
        #1;
        check("arst_rd_n", 32'(fifo_rd_n), 32'd1);
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_left", sample_left, 32'd0);
        check("arst_err", 32'(byte_count_err), 32'd0);
        repeat (2) @(negedge clk);
        bq.delete();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_fifo_reader.md
# usb_fifo_reader

Read-side controller for the FT245-style USB FIFO feeding the audio path. Sequences the active-low read strobe against RXF#, assembles received bytes into stereo left/right samples at the selected sample size, and presents complete frames to the I2S serializer through a valid/ready handshake. Sits between the FIFO_* board pins and the sample_processor / shift_register datapath, replacing the sample_generator as the audio source.

## Interface

- RD_LOW_CYCLES, 4: clk cycles fifo_rd_n is held low per byte (≥1; covers the FIFO's RD#-to-data-valid time).
- RD_HIGH_CYCLES, 3: clk cycles fifo_rd_n is held high after each strobe (≥1; RD# precharge).
- clk  in  1  main clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fifo_data  in  8  FIFO data bus.
- fifo_rxf_n  in  1  FIFO RXF#; low means a byte is available. Asynchronous.
- fifo_pwren_n  in  1  FIFO PWREN#; low means USB is enumerated. Asynchronous.
- fifo_rd_n  out  1  FIFO RD# strobe; registered.
- sample_size  in  3  size code: 0=8b, 1=12b, 3=16b, 4=24b, 5=32b; 2, 6 and 7 are treated as 16b.
- frame_ready  in  1  consumer accepts the presented frame.
- frame_valid  out  1  sample_left/sample_right hold a complete frame.
- sample_left  out  32  left sample, right-aligned, zero-extended.
- sample_right  out  32  right sample, right-aligned, zero-extended.
- byte_count_err  out  1  sticky flag: a partial frame was discarded; cleared only by rst.

## Operation

**Synchronization**
- fifo_rxf_n and fifo_pwren_n each pass through a 2-flop synchronizer. Below, rxf_s and pwr_s denote the synchronized values.
- fifo_data is not synchronized. It is sampled only on the last STROBE cycle.

**State machine: IDLE, STROBE, RECOVER**
- IDLE: fifo_rd_n=1.
  - Go to STROBE when rxf_s=0, pwr_s=0 and pending=0.
  - fifo_rd_n goes low on the same edge as the transition (registered).
- STROBE: fifo_rd_n=0 for exactly RD_LOW_CYCLES cycles.
  - On the last cycle's edge: capture fifo_data, set fifo_rd_n=1, go to RECOVER.
- RECOVER: fifo_rd_n=1 for RD_HIGH_CYCLES cycles, then go to IDLE.

**Byte assembly**
- Bytes per channel N: 8b=1, 12b=2, 16b=2, 24b=3, 32b=4.
- sample_size is latched when the first byte of a frame is captured. Changes mid-frame are ignored until the next frame.
- Byte order per channel is little-endian (first byte = bits 7:0). All N left bytes arrive, then all N right bytes.
- 12b mode: keep bits 11:0 of the 16-bit assembly and zero bits 15:12.
- Bits above the sample width read 0.

**Frame handoff (single output register plus assembly register)**
- When the last right byte is captured:
  - If frame_valid=0, or frame_ready=1 in that cycle: load the outputs and set frame_valid=1.
  - Otherwise: set pending=1 and hold the assembled frame.
- frame_valid=1 and frame_ready=1 with pending=1: load outputs from the assembly register, keep frame_valid=1, clear pending.
- frame_valid=1 and frame_ready=1 with pending=0 and no completion that cycle: clear frame_valid.
- Outputs are stable while frame_valid=1 and frame_ready=0.

**Boundaries**
- pwr_s=1 in STROBE: abort. On the next edge, fifo_rd_n=1 and the FSM goes to RECOVER (full precharge). No byte is captured.
- pwr_s=1 with a partial frame (byte index ≠0): discard the partial frame, reset the index to 0, set byte_count_err.
- The output frame and pending are preserved through both of the above.
- rxf_s rising during STROBE: the strobe still completes and the byte is captured (per FIFO protocol, RXF# goes high after RD# falls).
- Asynchronous rst at any time: force the reset values immediately.

## Timing

- Reset values:
  - State IDLE, fifo_rd_n=1, frame_valid=0.
  - sample_left=sample_right=0, pending=0, byte index=0, byte_count_err=0.
- rxf_n falling to fifo_rd_n low: 3 edges (2 synchronizer + 1 IDLE decision).
- Continuous-read byte period: RD_LOW_CYCLES + RD_HIGH_CYCLES + 1 cycles. With defaults: 8 cycles.
- Last-byte capture edge to frame_valid=1: 0 cycles. frame_valid rises on the capture edge when the output is free.
- At most one frame is buffered (pending). Reads stall while pending=1 and resume the cycle after pending clears.

## Test plan

- **16b, consumer always ready:** feed bytes 34 12 78 56 with rxf_n low → sample_left=0x00001234, sample_right=0x00005678. fifo_rd_n low pulses are 4 cycles wide, spaced 8 cycles apart.
- **12b and 24b:** for 12b, bytes FF AB … → left=0x00000BFF. For 24b, bytes 01 02 03 / 04 05 06 → left=0x00030201, right=0x00060504.
- **Backpressure:** frame_ready=0 with two frames available → first frame shown, second held as pending, fifo_rd_n stays high. Pulse frame_ready for 1 cycle → second frame appears on the next edge, reads resume.
- **PWREN# rises:** deassert fifo_pwren_n after 3 of 4 bytes (16b) → byte_count_err=1, no frame_valid. The next 4 bytes form a clean frame.
- **Abort mid-strobe and reset:** raise fifo_pwren_n during STROBE → fifo_rd_n high within 3 edges. Assert rst mid-strobe → fifo_rd_n=1 and frame_valid=0 immediately, with no clock edge.
- **sample_size change mid-frame:** switch 16b→32b after 1 byte → the current frame completes as 16b and the next frame uses 4 bytes per channel.
